alu_mdu: RTL

Parametrised ALU with an attached iterative multiply/divide unit for the MIPS datapath. Single-cycle ops (add, sub, and, or, slt) stay combinational, as today. Unsigned multiply and divide run over WIDTH cycles into internal HI/LO registers under a start/busy/done handshake. The controller stalls the pipeline on `busy` and reads results via mfhi/mflo encodings.

---
 rtl/alu_mdu.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu
//  Purpose  : Combinational ALU (add/sub/and/or/slt, mfhi/mflo) with an
//             attached iterative unsigned multiply/divide unit that writes
//             internal HI/LO registers under a start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  input  logic             start,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product high half (MUL) or partial remainder (DIV)
  logic [WIDTH:0]   acc_q, acc_d;
  // mq: multiplier shifting out / product low half (MUL), dividend shifting
  // out / quotient shifting in (DIV)
  logic [WIDTH-1:0] mq_q, mq_d;
  // m: latched multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  logic             w_launch_mul;
  logic             w_launch_div;
  logic             w_last;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH+1:0] w_div_trial;

  assign w_launch_mul = (state_q == S_IDLE) && start && (alucontrol == OP_MULTU);
  assign w_launch_div = (state_q == S_IDLE) && start && (alucontrol == OP_DIVU);
  assign w_last       = (cnt_q == CW'(1));

  // Shift-add step: add multiplicand when the current multiplier bit is set.
  // acc stays below 2^WIDTH between steps, so the sum fits in WIDTH+1 bits.
  assign w_addend  = mq_q[0] ? m_q : '0;
  assign w_mul_sum = acc_q + {1'b0, w_addend};

  // Restoring step: bring in the next dividend bit and trial-subtract. The
  // extra top bit of the trial is the borrow that decides the quotient bit.
  assign w_div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  assign w_div_trial = {1'b0, w_div_shift} - {2'b00, m_q};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: launch from idle, return after WIDTH iterations
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_launch_mul)      state_d = S_MUL;
        else if (w_launch_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (w_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath next values: operand capture, one iteration per cycle, and
  // HI/LO/divzero commit only on the final iteration
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;
    case (state_q)
      S_IDLE: begin
        if (w_launch_mul) begin
          acc_d = '0;
          mq_d  = srcb;
          m_d   = srca;
          cnt_d = CW'(WIDTH);
        end else if (w_launch_div) begin
          acc_d = '0;
          mq_d  = srca;
          m_d   = srcb;
          cnt_d = CW'(WIDTH);
        end
      end
      S_MUL: begin
        acc_d = {1'b0, w_mul_sum[WIDTH:1]};
        mq_d  = {w_mul_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (w_last) begin
          hi_d      = acc_d[WIDTH-1:0];
          lo_d      = mq_d;
          done_d    = 1'b1;
          divzero_d = 1'b0;
        end
      end
      S_DIV: begin
        if (!w_div_trial[WIDTH+1]) begin
          acc_d = w_div_trial[WIDTH:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = w_div_shift;
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (w_last) begin
          // A zero divisor never borrows: quotient is all ones and the
          // remainder ends up equal to the dividend, with no special case.
          hi_d      = acc_d[WIDTH-1:0];
          lo_d      = mq_d;
          done_d    = 1'b1;
          divzero_d = (m_q == '0);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign done    = done_q;
  assign divzero = divzero_q;

  // Single-cycle result mux, valid in any state
  always_comb begin
    aluout = '0;
    case (alucontrol)
      OP_ADD:  aluout = srca + srcb;
      OP_SUB:  aluout = srca - srcb;
      OP_AND:  aluout = srca & srcb;
      OP_OR:   aluout = srca | srcb;
      OP_SLT:  aluout = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      OP_MFHI: aluout = hi_q;
      OP_MFLO: aluout = lo_q;
      default: aluout = '0;
    endcase
  end

  // Zero flag follows the selected result
  always_comb begin
    zero = (aluout == '0);
  end

endmodule
`default_nettype wire
